// File: rtl/cdb_scheduler.sv
// Common data bus scheduler: per-FU holding registers, rotating-priority N-lane grant, registered broadcast.
// Optional statistics counters are enabled with `define CDB_SCHED_STATS_EN.
module cdb_scheduler #(
    parameter int unsigned N      = 2,
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned PREG_W = 6,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned ID_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*REG_W-1:0]  fu_reg_idx,
    input  logic [NUM_FU*PREG_W-1:0] fu_preg_idx,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [N-1:0]             cdb_valid,
    output logic [N*REG_W-1:0]       cdb_reg_idx,
    output logic [N*PREG_W-1:0]      cdb_preg_idx,
    output logic [N*DATA_W-1:0]      cdb_data,
    output logic [N*ID_W-1:0]        cdb_fu_id
`ifdef CDB_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_bcast_cnt,
    output logic [31:0]              stat_stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned IDX_W = ID_W + 1;

    typedef struct packed {
        logic [REG_W-1:0]  reg_idx;
        logic [PREG_W-1:0] preg_idx;
        logic [DATA_W-1:0] data;
    } hold_t;

    hold_t               hold_q [NUM_FU];
    logic [NUM_FU-1:0]   hold_v;
    logic [NUM_FU-1:0]   grant;
    logic [NUM_FU-1:0]   take;
    logic [2*NUM_FU-1:0] rot_dbl;
    logic [NUM_FU-1:0]   rot_v;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_next;
    logic [ID_W-1:0]     lane_src [N];
    logic [N-1:0]        lane_vld;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    n_grant;

    // Rotating scan from rr_ptr: k-th set bit of the rotated view goes to the next free lane.
    always_comb begin
        grant    = '0;
        lane_vld = '0;
        rr_next  = rr_ptr;
        n_grant  = '0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            lane_src[i] = '0;
        end
        rot_dbl = {hold_v, hold_v} >> rr_ptr;
        rot_v   = rot_dbl[NUM_FU-1:0];
        for (int k = 0; k < NUM_FU; k++) begin
            idx = IDX_W'(rr_ptr) + IDX_W'(k);
            if (idx >= IDX_W'(NUM_FU)) begin
                idx = idx - IDX_W'(NUM_FU);
            end
            if (rot_v[k] && (n_grant < CNT_W'(N))) begin
                grant = grant | (NUM_FU'(1) << idx);
                for (int i = 0; i < N; i++) begin
                    if (n_grant == CNT_W'(i)) begin
                        lane_vld[i] = 1'b1;
                        lane_src[i] = idx[ID_W-1:0];
                    end
                end
                rr_next = (idx == IDX_W'(NUM_FU - 1)) ? '0 : ID_W'(idx + IDX_W'(1));
                n_grant = n_grant + CNT_W'(1);
            end
        end
    end

    // A slot is free when empty or draining this cycle; never advertised during squash or reset.
    assign fu_ready = (reset && !squash) ? (~hold_v | grant) : '0;
    assign take     = fu_valid & fu_ready;

    // Holding registers and round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_v <= '0;
            rr_ptr <= '0;
            for (int j = 0; j < NUM_FU; j++) begin
                hold_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_FU; j++) begin
                if (take[j]) begin
                    hold_q[j] <= '{reg_idx:  fu_reg_idx[j*REG_W +: REG_W],
                                   preg_idx: fu_preg_idx[j*PREG_W +: PREG_W],
                                   data:     fu_data[j*DATA_W +: DATA_W]};
                end
            end
            hold_v <= squash ? '0 : ((hold_v & ~grant) | take);
            if (!squash && (|grant)) begin
                rr_ptr <= rr_next;
            end
        end
    end

    // Registered broadcast; lanes without a grant are zeroed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid    <= '0;
            cdb_reg_idx  <= '0;
            cdb_preg_idx <= '0;
            cdb_data     <= '0;
            cdb_fu_id    <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!squash && lane_vld[i]) begin
                    cdb_valid[i]                   <= 1'b1;
                    cdb_reg_idx[i*REG_W +: REG_W]    <= hold_q[lane_src[i]].reg_idx;
                    cdb_preg_idx[i*PREG_W +: PREG_W] <= hold_q[lane_src[i]].preg_idx;
                    cdb_data[i*DATA_W +: DATA_W]     <= hold_q[lane_src[i]].data;
                    cdb_fu_id[i*ID_W +: ID_W]        <= lane_src[i];
                end else begin
                    cdb_valid[i]                   <= 1'b0;
                    cdb_reg_idx[i*REG_W +: REG_W]    <= '0;
                    cdb_preg_idx[i*PREG_W +: PREG_W] <= '0;
                    cdb_data[i*DATA_W +: DATA_W]     <= '0;
                    cdb_fu_id[i*ID_W +: ID_W]        <= '0;
                end
            end
        end
    end

`ifdef CDB_SCHED_STATS_EN
    logic [31:0] bcast_inc;

    always_comb begin
        bcast_inc = '0;
        for (int i = 0; i < N; i++) begin
            bcast_inc = bcast_inc + 32'(cdb_valid[i]);
        end
    end

    // Counters survive squash and wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_bcast_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            stat_bcast_cnt <= stat_bcast_cnt + bcast_inc;
            if (|(hold_v & ~grant)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`else
    // Statistics counters not built.
`endif

endmodule

// File: doc/cdb_scheduler.md
Name: cdb_scheduler

Overview:
- Sequences completed functional-unit results onto the N-wide common data bus.
- Each FU has a one-entry holding register and a valid/ready handshake, so an FU that loses arbitration parks its result and moves on instead of recirculating it.
- A rotating-priority arbiter grants up to N held results per cycle and drives a registered CDB broadcast.
- Sits between the FU bank and the CDB consumers: RS wakeup, ROB complete, physical register file write.

Parameters:
- N, `N, number of CDB broadcast lanes per cycle (>=1)
- NUM_FU, `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_LOAD+`NUM_FU_STORE, number of requesting FUs (>=N)
- REG_W, 5, architectural register index width
- PREG_W, 6, physical register index width
- DATA_W, 32, result width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- squash  in  1  synchronous flush; discards all held and in-flight results
- fu_valid  in  NUM_FU  FU j presents a result
- fu_ready  out  NUM_FU  holding slot j can accept a result this cycle
- fu_reg_idx  in  NUM_FU*REG_W  architectural destination per FU
- fu_preg_idx  in  NUM_FU*PREG_W  physical destination per FU
- fu_data  in  NUM_FU*DATA_W  result value per FU
- cdb_valid  out  N  lane i broadcasts this cycle
- cdb_reg_idx  out  N*REG_W  lane i architectural destination
- cdb_preg_idx  out  N*PREG_W  lane i physical destination
- cdb_data  out  N*DATA_W  lane i value
- cdb_fu_id  out  N*$clog2(NUM_FU)  source FU of lane i

Behaviour:
- Reset (reset==0, async): all hold_v=0; rr_ptr=0; all cdb_* outputs 0; fu_ready forced 0 while reset is low.
- Capture: when fu_valid[j] && fu_ready[j] && !squash at a rising edge, hold[j] <= {reg_idx, preg_idx, data} and hold_v[j] <= 1.
- fu_ready[j] = !squash && (!hold_v[j] || grant[j]).
  - Combinational from state and arbiter output only; never depends on fu_valid.
- Arbitration (combinational, every cycle):
  - Scan hold_v circularly starting at index rr_ptr.
  - Grant the first min(N, popcount(hold_v)) set entries.
  - Lane 0 receives the first grant in scan order, lane 1 the next, and so on.
- Broadcast: at the edge, lane i registers the fields of its granted hold, sets cdb_valid[i]=1 and sets cdb_fu_id; ungranted lanes get cdb_valid=0 and zeroed fields.
  - Latency: result accepted at edge t, earliest broadcast is visible in the cycle after edge t+1 (2 edges).
- Granted hold: hold_v[j] cleared, unless recaptured the same edge (back-to-back, 1 result/FU/cycle sustained).
- rr_ptr update:
  - If any grant: rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
  - Else rr_ptr holds.
  - Bound: a held result is broadcast within ceil(NUM_FU/N) cycles.
- Empty (hold_v==0): all cdb_valid 0 next cycle; rr_ptr unchanged.
- Full (all hold_v=1, NUM_FU>N): exactly N grants; only granted FUs see fu_ready=1.
- Squash:
  - At the edge, all hold_v <= 0 and all cdb_valid <= 0.
  - A capture coincident with squash is dropped.
  - rr_ptr is unchanged.
  - Results broadcast in the squash cycle itself are still visible that cycle (already registered).
- Reset mid-operation: immediate return to reset state; in-flight results are lost.

Optional Feature:
- Macro CDB_SCHED_STATS_EN.
- Defined:
  - Adds outputs stat_bcast_cnt (32b) and stat_stall_cnt (32b).
  - stat_bcast_cnt counts cdb_valid lanes asserted, summed per cycle.
  - stat_stall_cnt increments each cycle some hold_v[j]=1 is not granted.
  - Both counters wrap at 2^32, clear on reset, and do not clear on squash.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan (N=2, NUM_FU=4):
- Single result: FU2 valid with preg=7, data=0xDEAD for 1 cycle -> cdb_valid=01, lane0 preg=7, data=0xDEAD, fu_id=2, visible 2 edges after acceptance; rr_ptr=3.
- Contention:
  - All 4 FUs valid for 1 cycle from rr_ptr=0 -> cycle A broadcasts FU0 on lane0 and FU1 on lane1; fu_ready=0011.
  - Next cycle broadcasts FU2/FU3; rr_ptr returns to 0.
- Fairness: FU0 and FU1 valid continuously, FU3 valid once -> FU3 broadcast within 2 cycles of capture; no FU waits more than 2 cycles.
- Back-to-back: FU1 valid every cycle for 5 cycles with data 1..5, others idle -> 5 consecutive broadcasts in order 1..5, fu_ready[1] held 1.
- Squash: holds FU0 and FU3 full, squash=1 with FU1 valid -> next cycle cdb_valid=00, hold_v=0000, FU1 result never broadcast; fu_ready=0 during squash.
- Async reset mid-stream: reset low between edges during active broadcast -> cdb_valid=00 and fu_ready=0000 immediately; after release rr_ptr=0 and a new FU3 result is broadcast normally.
